hs_rr_arbiter: RTL
==================

# hs_rr_arbiter

- Clocked round-robin arbiter that shares one four-phase req/ack pipeline channel between N requesters.
- Sits upstream of a `block` handshake stage: it selects one requester, forwards that requester's data word onto the stage's req_in/data_in, and relays the stage's ack back.
- A transaction is never interleaved with another.
- The block also counts completed transfers.

## Interface
- N, 4, number of requesters (2..8)
- DATA_WIDTH, 3, data word width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_in  in  N  per-requester four-phase request
- ack_out  out  N  per-requester four-phase acknowledge
- data_in  in  N*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_out  out  1  request to downstream stage
- ack_in  in  1  acknowledge from downstream stage
- data_out  out  DATA_WIDTH  registered data of granted requester
- grant  out  N  one-hot current owner; all zero when idle
- busy  out  1  high whenever state is not IDLE
- xfer_count  out  16  completed transactions, wraps 0xFFFF -> 0

## Operation
- FSM states: IDLE, SEND, ACKED, RELEASE.
- IDLE:
  - Requires at least one req_in bit high and ack_in low.
  - Winner is the first set req_in bit at or above ptr, searching upward modulo N.
  - Next edge: grant set, data_out loaded from the winner's slice, req_out=1, go to SEND.
  - If ack_in is high in IDLE, no grant is issued.
- SEND: when ack_in=1, set ack_out[g]=1 and go to ACKED.
- ACKED: when req_in[g]=0, set req_out=0 and go to RELEASE; ack_out[g] stays 1.
- RELEASE, when ack_in=0:
  - ack_out[g]=0, grant cleared.
  - ptr = (g+1) mod N, xfer_count += 1.
  - Go to IDLE.
- data_out holds its value from SEND through RELEASE, and keeps its last value in IDLE.
- Only ack_out[g] can be high, and only in ACKED and RELEASE.
- Non-granted requesters may raise or drop req_in freely; they see no response.
- If req_in[g] drops during SEND (protocol violation), it is ignored. The transaction continues, and ACKED exits immediately once reached.
- Reset, in any state including mid-transaction:
  - IDLE; req_out, ack_out, grant, busy = 0.
  - data_out = 0, ptr = 0, xfer_count = 0.
  - Downstream and requester recovery is the system's responsibility.

## Timing
- Without the configuration macro, each input-driven transition takes 1 cycle: the condition is sampled at edge t and the outputs change after edge t.
- Minimum transaction: 4 edges (grant, ack, req drop, release) when the environment responds in zero cycles.
- Back-to-back: the next grant comes at the earliest 1 edge after the RELEASE exit.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- HS_ARB_SYNC_EN:
  - Defined: req_in (all N bits) and ack_in each pass through a two-flop synchronizer before use, and every input-driven transition gains 2 cycles of latency.
  - data_in is sampled unsynchronized at grant; the protocol guarantees it is stable while the request is high.
- Undefined: inputs are used directly; the environment must be synchronous to clk.

## Structure
- Package hs_arb_pkg holds:
  - the state enum typedef (2-bit, IDLE=0, SEND=1, ACKED=2, RELEASE=3)
  - default N and DATA_WIDTH constants
  - the xfer_count width constant (16)
- Sub-module hs_sync2: parameterized-width two-flop synchronizer with synchronous active-high reset to 0. It is instantiated only under HS_ARB_SYNC_EN.

## Test plan
- Reset: assert rst for 2 cycles with req_in=4'b1111 -> all outputs 0 and state IDLE during reset. First grant after reset release is 4'b0001.
- Single transfer: req_in[2]=1, data_in slice 2 = 3'd5; respond ack_in=1, then drop req_in[2], then drop ack_in -> req_out, ack_out[2] and grant 4'b0100 follow the FSM, data_out=5 throughout, xfer_count=1, busy low at the end.
- Fairness: hold req_in=4'b1111 for 8 transactions -> grant order 0,1,2,3,0,1,2,3 and xfer_count=8.
- Stale ack: ack_in held high in IDLE with req_in[0]=1 -> no grant until ack_in goes low, then grant 4'b0001 on the next edge.
- Mid-transaction reset: assert rst while in ACKED -> req_out, ack_out and grant drop after that edge. ptr returns to 0 and xfer_count to 0.
- HS_ARB_SYNC_EN defined: repeat the single-transfer scenario -> each FSM transition lags its input by 3 edges instead of 1, with the same data_out and xfer_count results.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// Shared types and constants for the handshake round-robin arbiter.
package hs_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    ACKED   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int DEF_N          = 4;
  localparam int DEF_DATA_WIDTH = 3;
  localparam int XFER_W         = 16;

endpackage

// File: rtl/hs_sync2.sv
// Two-flop synchronizer, WIDTH bits wide, synchronous active-high reset to 0.
module hs_sync2
  import hs_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  // Stage 0 captures the asynchronous input, stage 1 resolves metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack channel between N
// requesters, with a completed-transfer counter.
// Optional macro HS_ARB_SYNC_EN: pass req_in and ack_in through two-flop
// synchronizers (adds two cycles to every input-driven transition).
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_in,
  output logic [N-1:0]            ack_out,
  input  logic [N*DATA_WIDTH-1:0] data_in,
  output logic                    req_out,
  input  logic                    ack_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [N-1:0]            grant,
  output logic                    busy,
  output logic [XFER_W-1:0]       xfer_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [N-1:0]     req_s;
  logic             ack_s;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

`ifdef HS_ARB_SYNC_EN
  logic [N:0] sync_q;

  hs_sync2 #(.WIDTH(N + 1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ack_in, req_in}),
    .q   (sync_q)
  );

  assign req_s = sync_q[N-1:0];
  assign ack_s = sync_q[N];
`else
  assign req_s = req_in;
  assign ack_s = ack_in;
`endif

  // Index following g, wrapping at N (N need not be a power of two)
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(N - 1)) return '0;
    return g + 1'b1;
  endfunction

  // Pick the first requester at or above ptr; scanning downward lets the
  // closest candidate overwrite farther ones
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (req_s[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Handshake FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_out    <= 1'b0;
      ack_out    <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      ptr        <= '0;
      gidx       <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A stale downstream ack blocks any new grant
          if (win_vld && !ack_s) begin
            gidx     <= win_idx;
            grant    <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            data_out <= data_in[win_idx*DATA_WIDTH +: DATA_WIDTH];
            req_out  <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (ack_s) begin
            ack_out <= grant;
            state   <= ACKED;
          end
        end
        ACKED: begin
          if (!req_s[gidx]) begin
            req_out <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            ack_out    <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            ptr        <= next_idx(gidx);
            xfer_count <= xfer_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
